rv32i_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the RV32i pipeline's instruction-fetch port and data port.

---
 rtl/rv32i_mem_arbiter_if.sv | 39 +++
 rtl/rv32i_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of the core-side (imem/dmem) and memory-side signals of rv32i_mem_arbiter.
// The arbiter uses the slave view: it serves the core's requests and issues memory cycles.
// The master view is the environment: the core ports plus the memory that answers.
interface rv32i_mem_arbiter_if;
  logic        imem_req_i;
  logic [31:0] imem_add_i;
  logic [31:0] imem_data_o;
  logic        imem_ready_o;
  logic        dmem_re_i;
  logic        dmem_we_i;
  logic [31:0] dmem_add_i;
  logic [31:0] dmem_di_i;
  logic [3:0]  dmem_ble_i;
  logic [31:0] dmem_do_o;
  logic        dmem_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_add_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_ble_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;

  modport slave (
    input  imem_req_i, imem_add_i, dmem_re_i, dmem_we_i, dmem_add_i, dmem_di_i,
           dmem_ble_i, mem_rdata_i, mem_ack_i,
    output imem_data_o, imem_ready_o, dmem_do_o, dmem_ready_o, mem_req_o, mem_we_o,
           mem_add_o, mem_wdata_o, mem_ble_o, stall_o, err_o
  );

  modport master (
    output imem_req_i, imem_add_i, dmem_re_i, dmem_we_i, dmem_add_i, dmem_di_i,
           dmem_ble_i, mem_rdata_i, mem_ack_i,
    input  imem_data_o, imem_ready_o, dmem_do_o, dmem_ready_o, mem_req_o, mem_we_o,
           mem_add_o, mem_wdata_o, mem_ble_o, stall_o, err_o
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-port memory between the RV32i fetch and data ports.
// IDLE arbitrates and latches the winner, BUSY holds mem_req_o until mem_ack_i, RESP gives
// the owner a one-cycle ready pulse. Data has priority, but after MAX_DATA_GRANTS data grants
// in a row with a fetch waiting the fetch is forced through.
// Optional build macro RV32I_ARB_TIMEOUT_EN: a BUSY access with no ack for TIMEOUT_CYCLES
// cycles is aborted; the owner gets ready with data 0 and err_o pulses. Without it err_o is 0.
module rv32i_mem_arbiter #(
  parameter int MAX_DATA_GRANTS = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  rv32i_mem_arbiter_if.slave bus
);

  localparam int               CNT_W   = $clog2(MAX_DATA_GRANTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_GRANTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               owner_data_reg, owner_data_next;  // 1: data port owns the access
  logic               we_reg, we_next;
  logic [31:0]        add_reg, add_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [3:0]         ble_reg, ble_next;
  logic [31:0]        rdata_reg, rdata_next;
  logic [CNT_W-1:0]   dgrant_cnt_reg, dgrant_cnt_next;

  logic               fetch_pend;
  logic               data_pend;
  logic               fetch_wins;

`ifdef RV32I_ARB_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic               err_reg, err_next;
`else
  logic               unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign fetch_pend = bus.imem_req_i;
  assign data_pend  = bus.dmem_re_i | bus.dmem_we_i;
  // A waiting fetch wins only when data is idle or data has used up its run of grants.
  assign fetch_wins = fetch_pend && (!data_pend || (dgrant_cnt_reg == CNT_MAX));

  // State and latched-transaction registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      owner_data_reg <= 1'b0;
      we_reg         <= 1'b0;
      add_reg        <= '0;
      wdata_reg      <= '0;
      ble_reg        <= '0;
      rdata_reg      <= '0;
      dgrant_cnt_reg <= '0;
`ifdef RV32I_ARB_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      owner_data_reg <= owner_data_next;
      we_reg         <= we_next;
      add_reg        <= add_next;
      wdata_reg      <= wdata_next;
      ble_reg        <= ble_next;
      rdata_reg      <= rdata_next;
      dgrant_cnt_reg <= dgrant_cnt_next;
`ifdef RV32I_ARB_TIMEOUT_EN
      tmo_cnt_reg    <= tmo_cnt_next;
      err_reg        <= err_next;
`endif
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for ack (or timeout) in BUSY, pulse in RESP.
  always_comb begin
    state_next      = state_reg;
    owner_data_next = owner_data_reg;
    we_next         = we_reg;
    add_next        = add_reg;
    wdata_next      = wdata_reg;
    ble_next        = ble_reg;
    rdata_next      = rdata_reg;
    dgrant_cnt_next = dgrant_cnt_reg;
`ifdef RV32I_ARB_TIMEOUT_EN
    tmo_cnt_next    = tmo_cnt_reg;
    err_next        = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (fetch_pend || data_pend) begin
          state_next = BUSY;
`ifdef RV32I_ARB_TIMEOUT_EN
          tmo_cnt_next = '0;
          err_next     = 1'b0;
`endif
          if (fetch_wins) begin
            owner_data_next = 1'b0;
            we_next         = 1'b0;
            add_next        = bus.imem_add_i;
            wdata_next      = '0;
            ble_next        = 4'hF;
            dgrant_cnt_next = '0;
          end else begin
            // Load and store both high is a store.
            owner_data_next = 1'b1;
            we_next         = bus.dmem_we_i;
            add_next        = bus.dmem_add_i;
            wdata_next      = bus.dmem_di_i;
            ble_next        = bus.dmem_ble_i;
            if (!fetch_pend) begin
              dgrant_cnt_next = '0;
            end else if (dgrant_cnt_reg != CNT_MAX) begin
              dgrant_cnt_next = dgrant_cnt_reg + CNT_W'(1);
            end
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack_i) begin
          rdata_next = bus.mem_rdata_i;
          state_next = RESP;
        end
`ifdef RV32I_ARB_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
`endif
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_req_o    = (state_reg == BUSY);
  assign bus.mem_we_o     = we_reg;
  assign bus.mem_add_o    = add_reg;
  assign bus.mem_wdata_o  = wdata_reg;
  assign bus.mem_ble_o    = ble_reg;

  assign bus.imem_ready_o = (state_reg == RESP) && !owner_data_reg;
  assign bus.dmem_ready_o = (state_reg == RESP) && owner_data_reg;
  assign bus.imem_data_o  = bus.imem_ready_o ? rdata_reg : 32'h0;
  // A store completion returns no data.
  assign bus.dmem_do_o    = (bus.dmem_ready_o && !we_reg) ? rdata_reg : 32'h0;

  assign bus.stall_o = (bus.imem_req_i & ~bus.imem_ready_o) |
                       ((bus.dmem_re_i | bus.dmem_we_i) & ~bus.dmem_ready_o);

`ifdef RV32I_ARB_TIMEOUT_EN
  assign bus.err_o = (state_reg == RESP) && err_reg;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: directed scenarios followed by a randomized
// run where core agents and a variable-latency memory are checked against a
// transaction-level model of the arbitration rules and memory contents.
module tb_rv32i_mem_arbiter;
  localparam int MAXG = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [31:0] mem_model [bit [29:0]];
  logic [31:0] grants [$];

  rv32i_mem_arbiter_if bus ();

  rv32i_mem_arbiter #(
    .MAX_DATA_GRANTS (MAXG),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_model[a[31:2]] = w;
  endtask

  task automatic idle_inputs();
    bus.imem_req_i  = 1'b0;
    bus.imem_add_i  = '0;
    bus.dmem_re_i   = 1'b0;
    bus.dmem_we_i   = 1'b0;
    bus.dmem_add_i  = '0;
    bus.dmem_di_i   = '0;
    bus.dmem_ble_i  = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req_o), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_mem_add"}, bus.mem_add_o, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'd0);
    chk({tag, "_mem_ble"}, 32'(bus.mem_ble_o), 32'd0);
    chk({tag, "_readys"}, 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd0);
    chk({tag, "_data"}, bus.imem_data_o | bus.dmem_do_o, 32'd0);
    chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
  endtask

  // Randomized run: agents hold requests until ready, memory acks after 0..3 BUSY cycles.
  task automatic run_random(input int ncycles);
    int          cnt = 0;
    int          lat = 0;
    int          f_age = 0;
    int          d_age = 0;
    int          ntx = 0;
    int unsigned kind;
    bit          prev_req = 1'b0;
    bit          resp_due = 1'b0;
    bit          owner_d = 1'b0;
    bit          f_done, d_done, fp, dp, fwin;
    logic        e_we = 1'b0;
    logic [31:0] e_add = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_data = '0;
    logic [3:0]  e_ble = '0;
    logic        exp_stall;
    idle_inputs();
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      f_done = 1'b0;
      d_done = 1'b0;
      exp_stall = (bus.imem_req_i & ~bus.imem_ready_o) |
                  ((bus.dmem_re_i | bus.dmem_we_i) & ~bus.dmem_ready_o);
      chk("rnd_stall", 32'(bus.stall_o), 32'(exp_stall));
      chk("rnd_err", 32'(bus.err_o), 32'd0);
      if (resp_due) begin
        chk("rnd_ready", 32'({bus.imem_ready_o, bus.dmem_ready_o}), owner_d ? 32'd1 : 32'd2);
        if (owner_d) chk("rnd_dmem_do", bus.dmem_do_o, e_data);
        else         chk("rnd_imem_data", bus.imem_data_o, e_data);
        chk("rnd_resp_req", 32'(bus.mem_req_o), 32'd0);
        ntx++;
        $display("txn %0d: %s addr=%h we=%0d ble=%h data=%h", ntx,
                 owner_d ? "data " : "fetch", e_add, e_we, e_ble, e_data);
        if (owner_d) d_done = 1'b1;
        else         f_done = 1'b1;
        resp_due = 1'b0;
      end else begin
        chk("rnd_quiet_ready", 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd0);
        chk("rnd_quiet_data", bus.imem_data_o | bus.dmem_do_o, 32'd0);
      end

      if (bus.mem_req_o && !prev_req) begin
        fp   = bus.imem_req_i;
        dp   = bus.dmem_re_i | bus.dmem_we_i;
        fwin = fp && (!dp || cnt == MAXG);
        if (!fp && !dp) begin
          chk("rnd_spurious_grant", 32'(bus.mem_req_o), 32'd0);
        end else if (fwin) begin
          owner_d = 1'b0;
          e_we    = 1'b0;
          e_add   = bus.imem_add_i;
          e_ble   = 4'hF;
          e_data  = mem_rd(bus.imem_add_i);
          cnt     = 0;
        end else begin
          owner_d = 1'b1;
          e_we    = bus.dmem_we_i;
          e_add   = bus.dmem_add_i;
          e_ble   = bus.dmem_ble_i;
          e_wdata = bus.dmem_di_i;
          e_data  = bus.dmem_we_i ? 32'h0 : mem_rd(bus.dmem_add_i);
          cnt     = fp ? ((cnt < MAXG) ? cnt + 1 : cnt) : 0;
        end
        lat = int'($urandom_range(0, 3));
      end

      if (bus.mem_req_o) begin
        chk("rnd_mem_add", bus.mem_add_o, e_add);
        chk("rnd_mem_we", 32'(bus.mem_we_o), 32'(e_we));
        chk("rnd_mem_ble", 32'(bus.mem_ble_o), 32'(e_ble));
        if (e_we) chk("rnd_mem_wdata", bus.mem_wdata_o, e_wdata);
        if (lat == 0) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem_rd(bus.mem_add_o);
          if (bus.mem_we_o) mem_wr(bus.mem_add_o, bus.mem_wdata_o, bus.mem_ble_o);
          resp_due = 1'b1;
        end else begin
          lat--;
          bus.mem_ack_i   = 1'b0;
          bus.mem_rdata_i = $urandom;
        end
      end else begin
        // Stray acks outside BUSY must be ignored.
        bus.mem_ack_i   = ($urandom_range(0, 7) == 0);
        bus.mem_rdata_i = $urandom;
      end
      prev_req = bus.mem_req_o;

      if (f_done) bus.imem_req_i = 1'b0;
      if (d_done) begin
        bus.dmem_re_i = 1'b0;
        bus.dmem_we_i = 1'b0;
      end
      if (bus.imem_req_i) begin
        f_age++;
      end else if ($urandom_range(0, 9) < 6) begin
        bus.imem_req_i = 1'b1;
        bus.imem_add_i = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        f_age = 0;
      end
      if (bus.dmem_re_i | bus.dmem_we_i) begin
        d_age++;
      end else if ($urandom_range(0, 9) < 7) begin
        kind = $urandom_range(0, 9);
        bus.dmem_re_i  = (kind <= 4) || (kind == 9);
        bus.dmem_we_i  = (kind >= 5);
        bus.dmem_add_i = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        bus.dmem_di_i  = $urandom;
        bus.dmem_ble_i = 4'($urandom_range(1, 15));
        d_age = 0;
      end
      if (f_age > 100 || d_age > 100) begin
        chk("rnd_starved_age", 32'(f_age > d_age ? f_age : d_age), 32'd0);
        break;
      end
    end
    idle_inputs();
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_regs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fetch with ack in the first BUSY cycle.
    bus.imem_req_i = 1'b1;
    bus.imem_add_i = 32'h100;
    @(negedge clk);
    chk("f_mem_req", 32'(bus.mem_req_o), 32'd1);
    chk("f_mem_add", bus.mem_add_o, 32'h100);
    chk("f_mem_ble", 32'(bus.mem_ble_o), 32'hF);
    chk("f_mem_we", 32'(bus.mem_we_o), 32'd0);
    chk("f_stall", 32'(bus.stall_o), 32'd1);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h00500093;
    @(negedge clk);
    chk("f_ready", 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd2);
    chk("f_data", bus.imem_data_o, 32'h00500093);
    chk("f_stall_resp", 32'(bus.stall_o), 32'd0);
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    bus.imem_req_i  = 1'b0;
    @(negedge clk);
    chk("f_pulse_end", 32'(bus.imem_ready_o), 32'd0);
    chk("f_data_end", bus.imem_data_o, 32'd0);

    // Simultaneous store and fetch: store first, then fetch.
    bus.imem_req_i = 1'b1;
    bus.imem_add_i = 32'h104;
    bus.dmem_we_i  = 1'b1;
    bus.dmem_add_i = 32'h2000;
    bus.dmem_di_i  = 32'hCAFEF00D;
    bus.dmem_ble_i = 4'b0011;
    @(negedge clk);
    chk("s_mem_we", 32'(bus.mem_we_o), 32'd1);
    chk("s_mem_add", bus.mem_add_o, 32'h2000);
    chk("s_mem_ble", 32'(bus.mem_ble_o), 32'h3);
    chk("s_mem_wdata", bus.mem_wdata_o, 32'hCAFEF00D);
    chk("s_stall_busy", 32'(bus.stall_o), 32'd1);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h11111111;
    @(negedge clk);
    chk("s_wr_ready", 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd1);
    chk("s_wr_do", bus.dmem_do_o, 32'd0);
    chk("s_stall_resp", 32'(bus.stall_o), 32'd1);
    bus.mem_ack_i = 1'b0;
    bus.dmem_we_i = 1'b0;
    @(negedge clk);
    chk("s_stall_idle", 32'(bus.stall_o), 32'd1);
    chk("s_idle_req", 32'(bus.mem_req_o), 32'd0);
    @(negedge clk);
    chk("s_f_mem_add", bus.mem_add_o, 32'h104);
    chk("s_f_mem_ble", 32'(bus.mem_ble_o), 32'hF);
    chk("s_f_mem_we", 32'(bus.mem_we_o), 32'd0);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("s_f_ready", 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd2);
    chk("s_f_data", bus.imem_data_o, 32'h12345678);
    idle_inputs();
    @(negedge clk);

    // Wait states: ack five cycles after mem_req_o rises, ready at request+7.
    bus.dmem_re_i  = 1'b1;
    bus.dmem_add_i = 32'h40;
    bus.dmem_di_i  = 32'h55AA55AA;
    bus.dmem_ble_i = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("w_mem_req", 32'(bus.mem_req_o), 32'd1);
      chk("w_mem_add", bus.mem_add_o, 32'h40);
      chk("w_mem_wdata", bus.mem_wdata_o, 32'h55AA55AA);
      chk("w_no_ready", 32'(bus.dmem_ready_o), 32'd0);
      if (k == 6) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hDEADBEEF;
      end
    end
    @(negedge clk);
    chk("w_ready", 32'(bus.dmem_ready_o), 32'd1);
    chk("w_do", bus.dmem_do_o, 32'hDEADBEEF);
    idle_inputs();
    @(negedge clk);

    // Fairness: continuous loads with a waiting fetch.
    grants.delete();
    bus.imem_req_i = 1'b1;
    bus.imem_add_i = 32'h200;
    bus.dmem_re_i  = 1'b1;
    bus.dmem_add_i = 32'h3000;
    bus.dmem_ble_i = 4'hF;
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      @(negedge clk);
      if (bus.dmem_ready_o) bus.dmem_add_i = bus.dmem_add_i + 32'd4;
      if (bus.imem_ready_o) bus.imem_req_i = 1'b0;
      if (bus.mem_req_o && !bus.mem_ack_i) begin
        grants.push_back(bus.mem_add_o);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'(c);
      end else begin
        bus.mem_ack_i = 1'b0;
      end
    end
    bus.imem_req_i = 1'b0;
    bus.dmem_re_i  = 1'b0;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    begin
      logic [31:0] exp_grants [6];
      logic [31:0] got;
      exp_grants = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h200, 32'h3010};
      for (int i = 0; i < 6; i++) begin
        got = (i < grants.size()) ? grants[i] : 32'hFFFFFFFF;
        chk($sformatf("fair_grant%0d", i), got, exp_grants[i]);
      end
    end
    idle_inputs();

    // Ack while IDLE is ignored.
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hA5A5A5A5;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_ready", 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd0);
      chk("idle_ack_req", 32'(bus.mem_req_o), 32'd0);
    end
    bus.mem_ack_i = 1'b0;

    // Reset in the middle of BUSY.
    bus.dmem_re_i  = 1'b1;
    bus.dmem_add_i = 32'h80;
    bus.dmem_ble_i = 4'hF;
    @(negedge clk);
    chk("r_busy_req", 32'(bus.mem_req_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_regs_zero("r_mid");
    rst = 1'b0;
    bus.dmem_re_i   = 1'b0;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h77777777;
    @(negedge clk);
    chk("r_late_ack1", 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd0);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk("r_late_ack2", 32'({bus.imem_ready_o, bus.dmem_ready_o}), 32'd0);

    // Memory never acks.
    bus.dmem_re_i  = 1'b1;
    bus.dmem_add_i = 32'h44;
    bus.dmem_ble_i = 4'hF;
`ifdef RV32I_ARB_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk("t_wait", 32'({bus.dmem_ready_o, bus.err_o}), 32'd0);
    end
    @(negedge clk);
    chk("t_ready", 32'(bus.dmem_ready_o), 32'd1);
    chk("t_err", 32'(bus.err_o), 32'd1);
    chk("t_do", bus.dmem_do_o, 32'd0);
    bus.dmem_re_i = 1'b0;
    @(negedge clk);
    chk("t_err_end", 32'(bus.err_o), 32'd0);
`else
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.dmem_ready_o || bus.err_o) seen = 1'b1;
    end
    chk("t_no_timeout", 32'(seen), 32'd0);
    chk("t_still_busy", 32'(bus.mem_req_o), 32'd1);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    chk("t_late_ready", 32'(bus.dmem_ready_o), 32'd1);
    chk("t_late_do", bus.dmem_do_o, 32'h0BADF00D);
    chk("t_late_err", 32'(bus.err_o), 32'd0);
`endif
    idle_inputs();
    @(negedge clk);

    // Randomized traffic from a clean reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_random(600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
